// File: rtl/act_sched_pkg.sv
// act_sched_pkg: shared types and helpers for the activation scheduler.
//   state_e          - scheduler FSM states
//   NUM_REQ_DEF/ID_W - default requester count and matching requester-id width
//   val_off/mask_off - bit offsets of bank slices in the flattened request buses
package act_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE
  } state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);

  // Low bit of bank's slice in the flattened req_values bus.
  function automatic int val_off(input int bank, input int num_neuron, input int addr_size);
    return bank * num_neuron * addr_size;
  endfunction

  // Low bit of bank's slice in the flattened req_mask bus.
  function automatic int mask_off(input int bank, input int num_neuron);
    return bank * num_neuron;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req        in  NUM_REQ  request vector
//   last_grant in  IDW      index granted last time (lowest priority now)
//   grant      out NUM_REQ  one-hot winner, zero when nothing requests
//   grant_id   out IDW      index of the winner (0 when nothing requests)
module rr_arbiter
  import act_sched_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id
);

  // Walk from the farthest candidate (last_grant itself) to the nearest
  // (last_grant+1); the last hit overwrites earlier ones, so the nearest wins.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    grant_id = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/activation_scheduler.sv
// activation_scheduler: time-shares one activation aggregator (LUT + output
// register) among NUM_REQ neuron banks, one batch in flight at a time.
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-bank request, one-hot accept (IDLE only)
//   req_values/req_mask      flattened per-bank sums and neuron valid bits
//   agg_start                pulse when a batch is issued to the aggregator
//   agg_values/agg_valid     batch presented to the aggregator
//   agg_out_values/_valid    aggregator results
//   resp_valid/id/values/mask  registered response, one-cycle pulse
// Optional: define ACT_SCHED_CHECK_EN to add a sticky err output flagging
// a CAPTURE where agg_out_valid differs from the issued mask.
module activation_scheduler
  import act_sched_pkg::*;
#(
  parameter  int NUM_REQ     = NUM_REQ_DEF,
  parameter  int NUM_NEURON  = 6,
  parameter  int ADDR_SIZE   = 10,
  parameter  int VALUE_SIZE  = 8,
  parameter  int LUT_LATENCY = 2,
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*NUM_NEURON*ADDR_SIZE-1:0] req_values,
  input  logic [NUM_REQ*NUM_NEURON-1:0]    req_mask,
  output logic                             agg_start,
  output logic [NUM_NEURON*ADDR_SIZE-1:0]  agg_values,
  output logic [NUM_NEURON-1:0]            agg_valid,
  input  logic [NUM_NEURON*VALUE_SIZE-1:0] agg_out_values,
  input  logic [NUM_NEURON-1:0]            agg_out_valid,
  output logic                             resp_valid,
  output logic [IDW-1:0]                   resp_id,
  output logic [NUM_NEURON*VALUE_SIZE-1:0] resp_values,
  output logic [NUM_NEURON-1:0]            resp_mask
`ifdef ACT_SCHED_CHECK_EN
  ,
  output logic                             err
`endif
);

  localparam int VAL_W = NUM_NEURON * ADDR_SIZE;
  localparam int RES_W = NUM_NEURON * VALUE_SIZE;
  localparam int CNT_W = $clog2(LUT_LATENCY + 1);

  state_e                  state_q;
  logic [IDW-1:0]          last_grant_q, cur_id_q, resp_id_q;
  logic [CNT_W-1:0]        wait_cnt_q;
  logic [VAL_W-1:0]        buf_values_q;
  logic [NUM_NEURON-1:0]   buf_mask_q, resp_mask_q;
  logic [RES_W-1:0]        resp_values_q;
  logic                    agg_start_q, resp_valid_q;

  logic [NUM_REQ-1:0]      grant;
  logic [IDW-1:0]          grant_id;
  logic [VAL_W-1:0]        sel_values;
  logic [NUM_NEURON-1:0]   sel_mask;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign req_ready = (state_q == IDLE) ? grant : '0;

  always_comb begin
    sel_values = req_values[val_off(int'(grant_id), NUM_NEURON, ADDR_SIZE) +: VAL_W];
    sel_mask   = req_mask[mask_off(int'(grant_id), NUM_NEURON) +: NUM_NEURON];
  end

`ifdef ACT_SCHED_CHECK_EN
  logic err_q;
  assign err = err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= IDW'(NUM_REQ - 1);
      cur_id_q      <= '0;
      wait_cnt_q    <= '0;
      buf_values_q  <= '0;
      buf_mask_q    <= '0;
      agg_start_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_values_q <= '0;
      resp_mask_q   <= '0;
`ifdef ACT_SCHED_CHECK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      agg_start_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|(req_valid & req_ready)) begin
            buf_values_q <= sel_values;
            buf_mask_q   <= sel_mask;
            cur_id_q     <= grant_id;
            last_grant_q <= grant_id;
            // Registered so the pulse lands in the ISSUE cycle.
            agg_start_q  <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt_q <= CNT_W'(LUT_LATENCY);
          state_q    <= WAIT;
        end
        WAIT: begin
          // LUT_LATENCY cycles spent here; leave as the count reaches 0.
          wait_cnt_q <= wait_cnt_q - CNT_W'(1);
          if (wait_cnt_q == CNT_W'(1)) state_q <= CAPTURE;
        end
        CAPTURE: begin
          resp_values_q <= agg_out_values;
          resp_mask_q   <= agg_out_valid;
          resp_id_q     <= cur_id_q;
          resp_valid_q  <= 1'b1;
`ifdef ACT_SCHED_CHECK_EN
          if (agg_out_valid != buf_mask_q) err_q <= 1'b1;
`endif
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign agg_start   = agg_start_q;
  assign agg_values  = buf_values_q;
  assign agg_valid   = buf_mask_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_values = resp_values_q;
  assign resp_mask   = resp_mask_q;

endmodule

// File: doc/activation_scheduler.md
# activation_scheduler

Shares the single output aggregator (activation LUT plus output register) among `NUM_REQ` neuron banks of the layer-multiplexed network. It uses round-robin arbitration and drives the selected bank's pre-activation sums into the aggregator. It waits the fixed LUT latency, then returns the activated values tagged with the requester ID. Exactly one batch is in flight at a time.

## Interface
- `NUM_REQ`, 4, number of requesting neuron banks (≥2)
- `NUM_NEURON`, 6, neurons per batch
- `ADDR_SIZE`, 10, width of one pre-activation sum (LUT address)
- `VALUE_SIZE`, 8, width of one activated value
- `LUT_LATENCY`, 2, cycles from aggregator input to LUT output, excluding the aggregator output register (≥1)

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NUM_REQ: per-bank batch request.
- `req_ready` out NUM_REQ: one-hot grant/accept.
- `req_values` in NUM_REQ*NUM_NEURON*ADDR_SIZE: sums; bank i occupies slice i.
- `req_mask` in NUM_REQ*NUM_NEURON: per-neuron valid bits; bank i occupies slice i.
- `agg_start` out 1: one-cycle pulse at batch issue.
- `agg_values` out NUM_NEURON*ADDR_SIZE: sums presented to the aggregator.
- `agg_valid` out NUM_NEURON: mask presented to the aggregator.
- `agg_out_values` in NUM_NEURON*VALUE_SIZE: aggregator outputs.
- `agg_out_valid` in NUM_NEURON: aggregator output valid bits.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_id` out $clog2(NUM_REQ): requester index of the response.
- `resp_values` out NUM_NEURON*VALUE_SIZE: activated values.
- `resp_mask` out NUM_NEURON: captured `agg_out_valid`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- **IDLE**
  - The arbiter picks the first requester with `req_valid` high, searching from `last_grant+1` and wrapping modulo NUM_REQ.
  - `req_ready` is one-hot to the winner, combinationally, and only in IDLE. It is all-zero when no request is pending or in any other state.
  - A handshake (`req_valid[i] & req_ready[i]`) latches slice i values and mask into the batch buffer, sets `cur_id=i` and `last_grant=i`, and moves to ISSUE.
- **ISSUE**
  - `agg_start`=1.
  - Load `wait_cnt=LUT_LATENCY`, go to WAIT.
- **WAIT**
  - Decrement `wait_cnt`.
  - At 0, go to CAPTURE.
- **CAPTURE**
  - Register `agg_out_values`/`agg_out_valid` into the response registers, set `resp_id=cur_id`, pulse `resp_valid` on the next cycle, go to IDLE.
- `agg_values`/`agg_valid` are driven from the batch buffer. They stay stable from ISSUE through CAPTURE, and retain their last value in IDLE.
- Requests not granted stay pending. Requesters must hold `req_valid` and data until `req_ready`.
- Responses are not backpressured. The consumer must accept `resp_valid` in any cycle.
- An all-zero `req_mask` is still scheduled. The response carries `resp_mask`=0.

## Timing
- Reset values:
  - FSM IDLE.
  - `last_grant=NUM_REQ-1`, so requester 0 wins first.
  - `req_ready`, `agg_start`, `resp_valid` are 0.
  - `agg_values`, `agg_valid`, `resp_id`, `resp_values`, `resp_mask` are 0.
- Handshake in cycle T: `agg_start` in T+1, CAPTURE in T+2+LUT_LATENCY, `resp_valid` in T+3+LUT_LATENCY.
- The FSM is back in IDLE in cycle T+3+LUT_LATENCY, so a new grant can coincide with `resp_valid`.
- Back-to-back throughput is one batch per LUT_LATENCY+3 cycles.
- Simultaneous requests resolve by the round-robin order above. Each continuously requesting bank is served within NUM_REQ batches.
- `rst` mid-batch returns to IDLE immediately. The in-flight batch is discarded, no `resp_valid` is produced, and `last_grant` resets.

## Configuration
- Macro `ACT_SCHED_CHECK_EN`.
- **Defined:**
  - Adds output `err` (1 bit, sticky, reset 0).
  - `err` sets when CAPTURE sees `agg_out_valid != agg_valid`, e.g. the LUT is not yet stable. The response is still delivered.
  - `err` clears only on `rst`.
- **Undefined:** no `err` port and no comparison logic.

## Structure
- Package `act_sched_pkg` holds:
  - the FSM state enum;
  - `ID_W = $clog2(NUM_REQ)`;
  - slice-offset helper functions for the flattened `req_values`/`req_mask`.
- Sub-module `rr_arbiter` (NUM_REQ): inputs are `req` and `last_grant`; outputs are one-hot `grant` and `grant_id`. It is purely combinational. The scheduler owns the `last_grant` register.

## Test plan
- **Single request:** reset, LUT_LATENCY=2, bank 2 requests with mask 6'b111111 in cycle 5. Expect `req_ready`=4'b0100 in cycle 5, `agg_start` in cycle 6, `resp_valid` with `resp_id`=2 in cycle 10, values equal to the LUT model.
- **All banks requesting:** all four banks request continuously from reset. Expect grant order 0,1,2,3,0 and grants spaced 5 cycles apart.
- **Mid-batch reset:** bank 1 is granted, then `rst` is asserted in the WAIT cycle. Expect no `resp_valid`, all outputs 0 next cycle, and requester 0 first after reset.
- **Partial mask:** bank 3 with `req_mask`=6'b000101. Expect `resp_mask`=6'b000101, and masked values still taken from the LUT.
- **Mask mismatch (macro defined):** the aggregator model forces `agg_out_valid`=0 at CAPTURE. Expect `err`=1 from the next cycle and held until `rst`.
- **Held requests:** bank 0 is granted while bank 1 is waiting. Check bank 1 holds data until granted and that its captured values match its final held data.
